// File: rtl/pwm_cmd_parser.sv
// pwm_cmd_parser: validates 5-byte UART config frames and drives the sine/PWM generator settings
module pwm_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] FREQ_RESET = 16'd100,
  parameter logic [7:0] AMP_RESET = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic [15:0] freq_word,
  output logic [7:0]  amplitude,
  output logic [1:0]  wave_sel,
  output logic        cfg_update,
  output logic [7:0]  err_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  typedef enum logic [2:0] {IDLE, CMD, DH, DL, CHK, RESP} state_t;
  state_t state, state_n;
  logic [7:0] cmd, cmd_n, dh, dh_n, dl, dl_n, txd_n, amp_n, err_n, err_sat;
  logic [15:0] freq_n;
  logic [1:0] wave_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic cfg_n;
  assign tx_valid = state == RESP;
  assign err_sat = err_cnt + {7'd0, err_cnt != 8'hFF};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cmd <= '0;
      dh <= '0;
      dl <= '0;
      tcnt <= '0;
      tx_data <= '0;
      freq_word <= FREQ_RESET;
      amplitude <= AMP_RESET;
      wave_sel <= '0;
      cfg_update <= 1'b0;
      err_cnt <= '0;
    end else begin
      state <= state_n;
      cmd <= cmd_n;
      dh <= dh_n;
      dl <= dl_n;
      tcnt <= tcnt_n;
      tx_data <= txd_n;
      freq_word <= freq_n;
      amplitude <= amp_n;
      wave_sel <= wave_n;
      cfg_update <= cfg_n;
      err_cnt <= err_n;
    end
  always_comb begin
    state_n = state;
    cmd_n = cmd;
    dh_n = dh;
    dl_n = dl;
    tcnt_n = '0;
    txd_n = tx_data;
    freq_n = freq_word;
    amp_n = amplitude;
    wave_n = wave_sel;
    cfg_n = 1'b0;
    err_n = err_cnt;
    // a byte arriving on the expiry edge wins over the timeout
    if (state inside {CMD, DH, DL, CHK} && !rx_valid) begin
      if (tcnt == TW'(TIMEOUT_CYCLES)) begin
        state_n = IDLE;
        err_n = err_sat;
      end else tcnt_n = tcnt + 1'b1;
    end
    case (state)
      IDLE: state_n = rx_valid && rx_data == SYNC ? CMD : IDLE;
      CMD: if (rx_valid) begin
        cmd_n = rx_data;
        state_n = DH;
      end
      DH: if (rx_valid) begin
        dh_n = rx_data;
        state_n = DL;
      end
      DL: if (rx_valid) begin
        dl_n = rx_data;
        state_n = CHK;
      end
      CHK: if (rx_valid) begin
        state_n = RESP;
        if (rx_data != (cmd ^ dh ^ dl)) begin
          txd_n = NAK;
          err_n = err_sat;
        end else begin
          cfg_n = cmd inside {8'h01, 8'h02, 8'h03};
          txd_n = cmd == 8'h10 ? err_cnt : cfg_n ? ACK : NAK;
          freq_n = cmd == 8'h01 ? {dh, dl} : freq_word;
          amp_n = cmd == 8'h02 ? dl : amplitude;
          wave_n = cmd == 8'h03 ? dl[1:0] : wave_sel;
        end
      end
      RESP: state_n = tx_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pwm_cmd_parser.sv
// tb_pwm_cmd_parser: directed and randomized frames checked each cycle against a frame-level model
module tb_pwm_cmd_parser;
  localparam int T = 8;
  logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic tx_valid, cfg_update;
  logic [7:0] tx_data, amplitude, err_cnt;
  logic [15:0] freq_word;
  logic [1:0] wave_sel;
  int errors = 0, checks = 0;
  bit rnd_ready = 1'b0;

  pwm_cmd_parser #(.TIMEOUT_CYCLES(T), .FREQ_RESET(16'd100), .AMP_RESET(8'd255)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .freq_word(freq_word), .amplitude(amplitude),
    .wave_sel(wave_sel), .cfg_update(cfg_update), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a frame is just the list of bytes collected since a sync byte
  logic [7:0] q[$];
  logic [15:0] m_freq;
  logic [7:0] m_amp, m_err, m_txd;
  logic [1:0] m_wave;
  logic m_txv, m_cfg;
  int sil;

  function automatic logic [7:0] sat(input logic [7:0] x);
    return x == 8'hFF ? x : x + 8'd1;
  endfunction

  function void model_reset();
    q.delete();
    m_freq = 16'd100;
    m_amp = 8'd255;
    m_wave = 2'd0;
    m_err = 8'd0;
    m_txd = 8'd0;
    m_txv = 1'b0;
    m_cfg = 1'b0;
    sil = 0;
  endfunction

  function void finish_frame();
    logic [7:0] c;
    c = q[1];
    if ((q[1] ^ q[2] ^ q[3]) != q[4]) begin
      m_txd = 8'h15;
      m_err = sat(m_err);
    end else if (c == 8'h01) begin
      m_freq = {q[2], q[3]};
      m_cfg = 1'b1;
      m_txd = 8'h06;
    end else if (c == 8'h02) begin
      m_amp = q[3];
      m_cfg = 1'b1;
      m_txd = 8'h06;
    end else if (c == 8'h03) begin
      m_wave = q[3][1:0];
      m_cfg = 1'b1;
      m_txd = 8'h06;
    end else m_txd = c == 8'h10 ? m_err : 8'h15;
    m_txv = 1'b1;
    q.delete();
  endfunction

  function void model_step();
    m_cfg = 1'b0;
    if (m_txv) begin
      if (tx_ready) m_txv = 1'b0;
    end else if (rx_valid && (q.size() > 0 || rx_data == 8'hA5)) begin
      q.push_back(rx_data);
      sil = 0;
      if (q.size() == 5) finish_frame();
    end else if (q.size() > 0) begin
      sil++;
      if (sil > T) begin
        q.delete();
        m_err = sat(m_err);
        sil = 0;
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) model_reset();
    else model_step();

  always @(negedge clk) begin
    check("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
    if (m_txv) check("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
    check("freq_word", {16'd0, freq_word}, {16'd0, m_freq});
    check("amplitude", {24'd0, amplitude}, {24'd0, m_amp});
    check("wave_sel", {30'd0, wave_sel}, {30'd0, m_wave});
    check("cfg_update", {31'd0, cfg_update}, {31'd0, m_cfg});
    check("err_cnt", {24'd0, err_cnt}, {24'd0, m_err});
  end

  task automatic tick();
    if (rnd_ready) tx_ready = 1'($urandom % 2);
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l, input logic [7:0] k);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(h);
    send_byte(l);
    send_byte(k);
  endtask

  task automatic check_reset_vals();
    check("rst freq_word", {16'd0, freq_word}, 32'd100);
    check("rst amplitude", {24'd0, amplitude}, 32'd255);
    check("rst wave_sel", {30'd0, wave_sel}, 32'd0);
    check("rst err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst tx_data", {24'd0, tx_data}, 32'd0);
    check("rst cfg_update", {31'd0, cfg_update}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check_reset_vals();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] c, h, l, k;
    int gap;
    tx_ready = 1'b1;
    do_reset();
    send_frame(8'h01, 8'h12, 8'h34, 8'h27);
    check("t1 freq_word", {16'd0, freq_word}, 32'h1234);
    check("t1 cfg_update", {31'd0, cfg_update}, 32'd1);
    check("t1 tx_valid", {31'd0, tx_valid}, 32'd1);
    check("t1 tx_data", {24'd0, tx_data}, 32'h06);
    tick();
    check("t1 cfg_update drop", {31'd0, cfg_update}, 32'd0);
    check("t1 tx_valid drop", {31'd0, tx_valid}, 32'd0);
    check("t1 err_cnt", {24'd0, err_cnt}, 32'd0);
    send_frame(8'h02, 8'h00, 8'h80, 8'h00);
    check("t2 tx_data", {24'd0, tx_data}, 32'h15);
    check("t2 amplitude", {24'd0, amplitude}, 32'd255);
    check("t2 err_cnt", {24'd0, err_cnt}, 32'd1);
    check("t2 cfg_update", {31'd0, cfg_update}, 32'd0);
    tick();
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h03);
    repeat (T + 2) tick();
    check("t3 timeout err_cnt", {24'd0, err_cnt}, 32'd1);
    check("t3 timeout no reply", {31'd0, tx_valid}, 32'd0);
    send_frame(8'h03, 8'h00, 8'h02, 8'h01);
    check("t3 wave_sel", {30'd0, wave_sel}, 32'd2);
    check("t3 tx_data", {24'd0, tx_data}, 32'h06);
    check("t3 err_cnt", {24'd0, err_cnt}, 32'd1);
    tick();
    tx_ready = 1'b0;
    send_frame(8'h02, 8'h00, 8'h80, 8'h82);
    check("t4 amplitude", {24'd0, amplitude}, 32'h80);
    for (int i = 0; i < 20; i++) begin
      if (i % 3 == 0) send_byte(i % 2 == 1 ? 8'hA5 : 8'($urandom));
      else tick();
      check("t4 tx_valid held", {31'd0, tx_valid}, 32'd1);
      check("t4 tx_data held", {24'd0, tx_data}, 32'h06);
    end
    tx_ready = 1'b1;
    tick();
    check("t4 tx_valid release", {31'd0, tx_valid}, 32'd0);
    check("t4 amplitude kept", {24'd0, amplitude}, 32'h80);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5 no reply", {31'd0, tx_valid}, 32'd0);
    send_frame(8'h02, 8'h00, 8'h40, 8'h42);
    check("t5 amplitude", {24'd0, amplitude}, 32'h40);
    check("t5 tx_data", {24'd0, tx_data}, 32'h06);
    tick();
    do_reset();
    repeat (256) begin
      send_byte(8'hA5);
      repeat (T + 2) tick();
    end
    check("t6 err_cnt sat", {24'd0, err_cnt}, 32'hFF);
    send_frame(8'h10, 8'h00, 8'h00, 8'h10);
    check("t6 status reply", {24'd0, tx_data}, 32'hFF);
    tick();
    send_frame(8'h7F, 8'h00, 8'h00, 8'h7F);
    check("t6 unknown NAK", {24'd0, tx_data}, 32'h15);
    check("t6 err_cnt held", {24'd0, err_cnt}, 32'hFF);
    tick();
    do_reset();
    rnd_ready = 1'b1;
    for (int f = 0; f < 300; f++) begin
      case ($urandom % 6)
        0: c = 8'h01;
        1: c = 8'h02;
        2: c = 8'h03;
        3: c = 8'h10;
        default: c = 8'($urandom);
      endcase
      h = 8'($urandom);
      l = 8'($urandom);
      k = c ^ h ^ l;
      if ($urandom % 5 == 0) k = k ^ 8'(1 << ($urandom % 8));
      if ($urandom % 6 == 0) send_byte(8'($urandom));
      for (int b = 0; b < 5; b++) begin
        send_byte(b == 0 ? 8'hA5 : b == 1 ? c : b == 2 ? h : b == 3 ? l : k);
        gap = $urandom % 10 == 0 ? int'($urandom_range(T - 1, T + 2)) : int'($urandom % 2);
        repeat (gap) tick();
      end
    end
    rnd_ready = 1'b0;
    tx_ready = 1'b1;
    repeat (T + 5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pwm_cmd_parser.md
# pwm_cmd_parser

Byte-level command parser between the UART receiver and the sine/PWM generator. Consumes received bytes, validates 5-byte frames (sync, command, 16-bit payload, XOR checksum), and updates the generator's frequency word, amplitude and waveform select. Returns a one-byte ACK, NAK or status reply to the UART transmitter. Tracks framing errors in a saturating counter.

## Interface
- TIMEOUT_CYCLES, 50000: idle cycles allowed between bytes of one frame
- FREQ_RESET, 16'd100: reset value of freq_word
- AMP_RESET, 8'd255: reset value of amplitude
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous and active-low
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- tx_ready  in  1  transmitter can accept a byte
- tx_valid  out  1  reply byte valid; held until accepted
- tx_data  out  8  reply byte
- freq_word  out  16  phase increment for sine generator
- amplitude  out  8  amplitude scale for sine generator
- wave_sel  out  2  waveform select
- cfg_update  out  1  one-cycle pulse when any config output changes
- err_cnt  out  8  saturating count of bad-checksum and timed-out frames

## Operation
- Frame format: 0xA5, CMD, DH, DL, CHK, where CHK = CMD ^ DH ^ DL.
- Commands:
  - 0x01: freq_word <= {DH,DL}, reply ACK 0x06.
  - 0x02: amplitude <= DL (DH ignored but checksummed), reply ACK.
  - 0x03: wave_sel <= DL[1:0] (DL[7:2] ignored), reply ACK.
  - 0x10: no config change, reply tx_data = err_cnt (value before this frame).
  - Any other CMD with a good checksum: reply NAK 0x15, no update, err_cnt unchanged.
- Bad checksum: reply NAK, no update, err_cnt += 1 (saturates at 255).
- States: IDLE -> CMD -> DH -> DL -> CHK -> RESP -> IDLE.
  - Each arrow is taken on an edge with rx_valid=1, except RESP -> IDLE, taken on an edge with tx_ready=1.
  - In IDLE, bytes other than 0xA5 are dropped silently.
  - In IDLE, 0xA5 moves to CMD.
- Inter-byte timeout:
  - In CMD, DH, DL or CHK, a counter clears on each accepted byte and increments every cycle with rx_valid=0.
  - When it reaches TIMEOUT_CYCLES, the next edge returns to IDLE, err_cnt += 1, no reply.
  - If rx_valid=1 arrives on that same edge, the byte is accepted and the timeout is not taken.
- In RESP, rx_valid bytes are dropped and not counted; a 0xA5 here does not start a frame.
- cfg_update pulses even when the written value equals the old value (0x01/0x02/0x03 with good CHK).
- Reset values:
  - freq_word = FREQ_RESET, amplitude = AMP_RESET, wave_sel = 0.
  - err_cnt = 0, tx_valid = 0, tx_data = 0x00, cfg_update = 0, state IDLE, timeout counter 0.
- Reset mid-frame discards the partial frame; no reply is sent.

## Timing
- CHK byte sampled at edge N.
  - Config outputs, cfg_update=1, tx_valid=1 and tx_data become visible after edge N (latency 1).
  - cfg_update returns to 0 after edge N+1.
- tx_valid/tx_data are stable from edge N until the first edge with tx_ready=1; tx_valid=0 after that edge.
- tx_ready=1 already at edge N+1 gives a one-cycle tx_valid; a new frame's 0xA5 can be accepted from edge N+2.
- Back-to-back rx_valid on consecutive cycles is supported; no backpressure exists on the rx side.
- err_cnt updates at the same edge as the NAK or timeout return.

## Test plan
- Rx A5 01 12 34 27, tx_ready=1 -> freq_word=0x1234, one cfg_update pulse, tx_data=0x06 for one cycle, err_cnt=0.
- Rx A5 02 00 80 00 (bad CHK) -> tx_data=0x15, amplitude stays 255, err_cnt=1, no cfg_update.
- Rx A5 03, then silence for TIMEOUT_CYCLES+2 cycles, then A5 03 00 02 01 -> err_cnt=1, no reply to the first frame, wave_sel=2, ACK.
- Rx A5 02 00 80 82 with tx_ready=0 for 20 cycles, plus rx bytes during the wait -> tx_valid held steady, dropped bytes cause no state change, amplitude=0x80.
- Assert rst_n=0 after A5 01 12 of a frame -> all outputs at reset values, tx_valid stays 0; a following full valid frame succeeds.
- Force 256 timeouts, then A5 10 00 00 10 -> reply tx_data=0xFF (err_cnt saturates at 255); A5 7F 00 00 7F -> NAK, err_cnt stays 255.
